// File: rtl/disp_scan_ctrl_pkg.sv
// datatype_package: shared message, scan-state and seven-segment glyph definitions
package datatype_package;

    typedef enum logic [2:0] {
        EMPTY_MSG,
        WELCOME_MSG,
        READY_MSG,
        STOPWATCH_MSG,
        WIN_MSG
    } msg_t;

    typedef enum logic {
        DEAD_S,
        ON_S
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // letter glyph codes, looked up in GLYPH_SEG
    localparam logic [3:0] G_BLANK = 4'd0;
    localparam logic [3:0] G_H     = 4'd1;
    localparam logic [3:0] G_E     = 4'd2;
    localparam logic [3:0] G_L     = 4'd3;
    localparam logic [3:0] G_O     = 4'd4;
    localparam logic [3:0] G_R     = 4'd5;
    localparam logic [3:0] G_D     = 4'd6;
    localparam logic [3:0] G_Y     = 4'd7;
    localparam logic [3:0] G_G     = 4'd8;
    localparam logic [3:0] G_OL    = 4'd9;

    localparam logic [6:0] DIGIT_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
    };

    localparam logic [6:0] GLYPH_SEG [16] = '{
        SEG_BLANK, 7'h09, 7'h06, 7'h47, 7'h40, 7'h2F, 7'h21, 7'h11,
        7'h42, 7'h23, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK
    };

    // element [3] is the leftmost digit
    localparam logic [3:0][3:0] WELCOME_G = {G_H, G_E, G_L, G_O};
    localparam logic [3:0][3:0] READY_G   = {G_R, G_E, G_D, G_Y};
    localparam logic [3:0][3:0] WIN_G     = {G_G, G_OL, G_OL, G_D};

endpackage

// File: rtl/disp_scan_ctrl_seg_decoder.sv
// seg_decoder: BCD digit or letter glyph code to active-low {g,f,e,d,c,b,a}
module seg_decoder
    import datatype_package::*;
(
    input  logic [3:0] code,
    input  logic       glyph,
    output logic [6:0] seg
);

    assign seg = glyph ? GLYPH_SEG[code] : DIGIT_SEG[code];

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: four-digit multiplexed display scanner with frame latching and win blink
module disp_scan_ctrl
    import datatype_package::*;
#(
    parameter int SCAN_ON_TICKS = 4,
    parameter int DEAD_TICKS    = 1,
    parameter int BLINK_FRAMES  = 8
) (
    input  logic            clk_i,
    input  logic            res_ni,
    input  msg_t            msg_i,
    input  logic [3:0][3:0] digits_i,
    output logic [3:0]      an_o,
    output logic [6:0]      seg_o,
    output logic            dp_o
);

    localparam int MAX_TICKS = SCAN_ON_TICKS > DEAD_TICKS ? SCAN_ON_TICKS : DEAD_TICKS;
    localparam int TW = $clog2(MAX_TICKS + 1);
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [TW-1:0] DEAD_LAST  = TW'(DEAD_TICKS - 1);
    localparam logic [TW-1:0] ON_LAST    = TW'(SCAN_ON_TICKS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    scan_state_t     state, ns;
    logic [1:0]      idx, nidx;
    logic [TW-1:0]   tick, ntick;
    logic [FW-1:0]   frame_cnt, nframe;
    logic            blink, nblink;
    msg_t            lat_msg, nmsg;
    logic [3:0][3:0] lat_digits, ndig;
    logic            slot_end, latch, wrap, msg_change, frame_done, n_on;
    logic [3:0]      code;
    logic            glyph;
    logic [6:0]      dec_seg;

    assign slot_end   = tick == (state == DEAD_S ? DEAD_LAST : ON_LAST);
    assign latch      = state == DEAD_S && slot_end && idx == 2'd0;
    assign wrap       = state == ON_S && slot_end && idx == 2'd3;
    assign msg_change = latch && msg_i != lat_msg;
    assign frame_done = wrap && frame_cnt == FRAME_LAST;

    // next-state values; outputs are decoded from these so they land with the state
    always_comb begin
        ns     = slot_end ? (state == DEAD_S ? ON_S : DEAD_S) : state;
        nidx   = state == ON_S && slot_end ? idx + 2'd1 : idx;
        ntick  = slot_end ? '0 : tick + TW'(1);
        nmsg   = latch ? msg_i : lat_msg;
        ndig   = latch ? digits_i : lat_digits;
        nframe = msg_change || frame_done ? '0 : wrap ? frame_cnt + FW'(1) : frame_cnt;
        nblink = msg_change ? 1'b0 : frame_done ? ~blink : blink;
        n_on   = ns == ON_S;
    end

    always_comb begin
        glyph = nmsg != STOPWATCH_MSG;
        code  = nmsg == STOPWATCH_MSG ? ndig[nidx] :
                nmsg == WELCOME_MSG   ? WELCOME_G[nidx] :
                nmsg == READY_MSG     ? READY_G[nidx] :
                nmsg == WIN_MSG       ? WIN_G[nidx] : G_BLANK;
    end

    seg_decoder u_seg_decoder (
        .code  (code),
        .glyph (glyph),
        .seg   (dec_seg)
    );

    always_ff @(posedge clk_i or negedge res_ni) begin
        if (!res_ni) begin
            state      <= DEAD_S;
            idx        <= 2'd0;
            tick       <= '0;
            frame_cnt  <= '0;
            blink      <= 1'b0;
            lat_msg    <= EMPTY_MSG;
            lat_digits <= '0;
            an_o       <= 4'b1111;
            seg_o      <= SEG_BLANK;
            dp_o       <= 1'b1;
        end else begin
            state      <= ns;
            idx        <= nidx;
            tick       <= ntick;
            frame_cnt  <= nframe;
            blink      <= nblink;
            lat_msg    <= nmsg;
            lat_digits <= ndig;
            an_o       <= n_on ? ~(4'b0001 << nidx) : 4'b1111;
            seg_o      <= n_on && !(nmsg == WIN_MSG && nblink) ? dec_seg : SEG_BLANK;
            dp_o       <= !(n_on && nidx == 2'd2 && nmsg == STOPWATCH_MSG);
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: randomized self-checking bench against a frame-timing reference model
module tb_disp_scan_ctrl;
    import datatype_package::*;

    localparam int ST = 4, DT = 1, BF = 2, SL = ST + DT, FRAME = 4 * SL;

    logic            clk = 1'b0;
    logic            res_ni = 1'b0;
    msg_t            msg = EMPTY_MSG;
    logic [3:0][3:0] digits = '0;
    logic [3:0]      an_o;
    logic [6:0]      seg_o;
    logic            dp_o;

    int checks = 0, failures = 0;
    int k, m_j, cur_slot;
    bit cur_on;
    msg_t m_msg;
    logic [3:0][3:0] m_dig;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic exp_dp;

    disp_scan_ctrl #(.SCAN_ON_TICKS(ST), .DEAD_TICKS(DT), .BLINK_FRAMES(BF)) dut (
        .clk_i    (clk),
        .res_ni   (res_ni),
        .msg_i    (msg),
        .digits_i (digits),
        .an_o     (an_o),
        .seg_o    (seg_o),
        .dp_o     (dp_o)
    );

    always #5 clk = ~clk;

    // lit segments (active-high gfedcba) of a printable character
    function automatic logic [6:0] lit(logic [7:0] ch);
        case (ch)
            "0": return 7'h3F; "1": return 7'h06; "2": return 7'h5B; "3": return 7'h4F;
            "4": return 7'h66; "5": return 7'h6D; "6": return 7'h7D; "7": return 7'h07;
            "8": return 7'h7F; "9": return 7'h6F; "-": return 7'h40; "H": return 7'h76;
            "E": return 7'h79; "L": return 7'h38; "O": return 7'h3F; "r": return 7'h50;
            "d": return 7'h5E; "Y": return 7'h6E; "G": return 7'h3D; "o": return 7'h5C;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [7:0] glyph_char(msg_t m, logic [3:0][3:0] d, int slot);
        logic [31:0] s;
        s = m == WELCOME_MSG ? "HELO" : m == READY_MSG ? "rEdY" : m == WIN_MSG ? "Good" : "    ";
        if (m == STOPWATCH_MSG) return d[slot] > 4'd9 ? 8'h2D : 8'h30 + 8'(d[slot]);
        return s[slot*8 +: 8];
    endfunction

    task automatic model_reset();
        k = 0;
        m_msg = EMPTY_MSG;
        m_dig = '0;
        m_j = -1;
    endtask

    // advance one edge and compute what the display should show afterwards
    task automatic tick();
        int n, pos;
        @(posedge clk);
        k++;
        n = k - DT;
        if (n >= 0 && n % FRAME == 0) begin
            m_j = msg != m_msg ? 0 : m_j + 1;
            m_msg = msg;
            m_dig = digits;
        end
        pos = n < 0 ? 0 : n % FRAME;
        cur_slot = pos / SL;
        cur_on = n >= 0 && pos % SL < ST;
        exp_an = 4'b1111;
        if (cur_on) exp_an[cur_slot] = 1'b0;
        exp_seg = !cur_on || (m_msg == WIN_MSG && (m_j / BF) % 2 == 1) ? 7'h7F
                : ~lit(glyph_char(m_msg, m_dig, cur_slot));
        exp_dp = !(cur_on && cur_slot == 2 && m_msg == STOPWATCH_MSG);
        #1;
    endtask

    always @(negedge clk) begin
        checks++;
        if ($countones(~an_o) > 1) begin
            failures++;
            $display("FAIL onehot an=%b required at most one low bit", an_o);
        end
    end

    task automatic test_reset();
        res_ni = 1'b0;
        msg = STOPWATCH_MSG;
        digits = {4'd1, 4'd2, 4'd3, 4'd4};
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({an_o, seg_o, dp_o} !== {4'b1111, 7'h7F, 1'b1}) begin
            failures++;
            $display("FAIL reset_state got an=%b seg=%h dp=%b required an=1111 seg=7f dp=1", an_o, seg_o, dp_o);
        end
        @(negedge clk);
        res_ni = 1'b1;
        model_reset();
        tick();
        checks++;
        if ({an_o, seg_o, dp_o} !== {4'b1110, 7'h19, 1'b1}) begin
            failures++;
            $display("FAIL first_on got an=%b seg=%h dp=%b required an=1110 seg=19 dp=1", an_o, seg_o, dp_o);
        end
    endtask

    task automatic test_stopwatch();
        int n_idx0 = 0, n_dp = 0;
        repeat (FRAME) begin
            tick();
            n_idx0 += int'(an_o === 4'b1110);
            n_dp += int'(dp_o === 1'b0);
            checks++;
            if ({an_o, seg_o, dp_o} !== {exp_an, exp_seg, exp_dp}) begin
                failures++;
                $display("FAIL stopwatch k=%0d got %b/%h/%b required %b/%h/%b", k, an_o, seg_o, dp_o, exp_an, exp_seg, exp_dp);
            end
        end
        checks++;
        if (n_idx0 != 4 || n_dp != 4) begin
            failures++;
            $display("FAIL slot_len idx0_cycles=%0d dp_cycles=%0d required 4 and 4", n_idx0, n_dp);
        end
    endtask

    task automatic test_tearing();
        bit found = 0, seen2 = 0;
        for (int i = 0; i < FRAME && !found; i++) begin
            tick();
            found = cur_on && cur_slot == 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL tear_sync idx1 slot not reached within %0d cycles", FRAME);
        end
        digits = {4'd9, 4'd9, 4'd9, 4'd9};
        repeat (2 * FRAME) begin
            tick();
            if (!seen2 && cur_on && cur_slot == 2) begin
                seen2 = 1;
                checks++;
                if (seg_o !== 7'h24) begin
                    failures++;
                    $display("FAIL tear_old got seg=%h required 24", seg_o);
                end
            end
            checks++;
            if ({an_o, seg_o, dp_o} !== {exp_an, exp_seg, exp_dp}) begin
                failures++;
                $display("FAIL tearing k=%0d got %b/%h/%b required %b/%h/%b", k, an_o, seg_o, dp_o, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    task automatic test_win_blink();
        int blanked = 0;
        msg = WIN_MSG;
        repeat (7 * FRAME) begin
            tick();
            blanked += int'(an_o !== 4'b1111 && seg_o === 7'h7F);
            checks++;
            if ({an_o, seg_o, dp_o} !== {exp_an, exp_seg, exp_dp}) begin
                failures++;
                $display("FAIL win_blink k=%0d got %b/%h/%b required %b/%h/%b", k, an_o, seg_o, dp_o, exp_an, exp_seg, exp_dp);
            end
        end
        checks++;
        if (blanked < 2 * 4 * ST) begin
            failures++;
            $display("FAIL win_blank blanked_on_cycles=%0d required at least %0d", blanked, 2 * 4 * ST);
        end
    endtask

    task automatic test_dash();
        bit found = 0;
        msg = STOPWATCH_MSG;
        digits = {4'd9, 4'd8, 4'd7, 4'hC};
        repeat (2 * FRAME) begin
            tick();
            checks++;
            if ({an_o, seg_o, dp_o} !== {exp_an, exp_seg, exp_dp}) begin
                failures++;
                $display("FAIL dash k=%0d got %b/%h/%b required %b/%h/%b", k, an_o, seg_o, dp_o, exp_an, exp_seg, exp_dp);
            end
        end
        for (int i = 0; i < FRAME && !found; i++) begin
            tick();
            found = cur_on && cur_slot == 0;
        end
        checks++;
        if (!found || seg_o !== 7'h3F) begin
            failures++;
            $display("FAIL dash_seg found=%0d got seg=%h required 3f", found, seg_o);
        end
    endtask

    task automatic test_async_reset();
        bit found = 0;
        for (int i = 0; i < FRAME && !found; i++) begin
            tick();
            found = cur_on && cur_slot == 1;
        end
        #2;
        res_ni = 1'b0;
        #1;
        checks++;
        if (!found || {an_o, seg_o, dp_o} !== {4'b1111, 7'h7F, 1'b1}) begin
            failures++;
            $display("FAIL async_reset found=%0d got an=%b seg=%h dp=%b required 1111/7f/1", found, an_o, seg_o, dp_o);
        end
        @(negedge clk);
        res_ni = 1'b1;
        model_reset();
        tick();
        checks++;
        if (an_o !== 4'b1110) begin
            failures++;
            $display("FAIL release_on got an=%b required 1110", an_o);
        end
        repeat (FRAME) begin
            tick();
            checks++;
            if ({an_o, seg_o, dp_o} !== {exp_an, exp_seg, exp_dp}) begin
                failures++;
                $display("FAIL post_reset k=%0d got %b/%h/%b required %b/%h/%b", k, an_o, seg_o, dp_o, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    task automatic test_random();
        repeat (60 * FRAME) begin
            if ($urandom_range(0, 39) == 0) msg = msg_t'($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0)
                for (int d = 0; d < 4; d++) digits[d] = 4'($urandom_range(0, 15));
            tick();
            checks++;
            if ({an_o, seg_o, dp_o} !== {exp_an, exp_seg, exp_dp}) begin
                failures++;
                $display("FAIL random k=%0d msg=%0d got %b/%h/%b required %b/%h/%b", k, m_msg, an_o, seg_o, dp_o, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stopwatch();
        test_tearing();
        test_win_blink();
        test_dash();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
